// File: rtl/lsu_bus_if.sv
// lsu_bus_if: handshake bundle for the load/store unit.
//   in_*  : request channel from the execute stage (valid/ready).
//   out_* : response channel back to the pipeline (valid/ready).
//   mem_* : single-outstanding memory port (req/gnt, then rvalid).
// The slave modport is the LSU's view; master is the surrounding environment.
interface lsu_bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned NB = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic              in_wen;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rerr;

  modport slave (
    input  in_valid, in_wen, in_funct3, in_addr, in_wdata, out_ready,
           mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
    output in_ready, out_valid, out_rdata, out_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output in_valid, in_wen, in_funct3, in_addr, in_wdata, out_ready,
           mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
    input  in_ready, out_valid, out_rdata, out_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_bus.sv
// lsu_bus: multi-cycle load/store unit on a request/response handshake bus.
//   clk : rising-edge clock.
//   rst : synchronous, active-high reset.
//   bus : lsu_bus_if.slave -- request in, response out, memory port.
// Accepts one access in IDLE, issues it on the memory port (REQ), waits for
// the single response beat (WAIT), then presents the formatted result (RESP).
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses error out
// without touching the bus; otherwise they are issued with lanes truncated.
module lsu_bus #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_bus_if.slave   bus
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     strb_q, strb_d;
  logic [OW-1:0]     off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [OW-1:0]     offset;
  logic [NB-1:0]     size_mask;
  logic              legal;
  logic              acc_err;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;
  logic [DATA_W-1:0] fmt;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              misaligned;
`endif

  // Request decode: legality, byte-lane mask and optional alignment trap.
  always_comb begin
    offset = bus.in_addr[OW-1:0];
    case (bus.in_funct3[1:0])
      2'd0:    size_mask = NB'(1);
      2'd1:    size_mask = NB'(3);
      2'd2:    size_mask = NB'(4'hF);
      default: size_mask = '1;
    endcase
    case (bus.in_funct3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
      3'd3, 3'd6:                   legal = (DATA_W == 64);
      default:                      legal = 1'b0;
    endcase
    if (bus.in_wen && bus.in_funct3[2]) legal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = |(offset & OW'((32'd1 << bus.in_funct3[1:0]) - 32'd1));
    acc_err    = !legal || misaligned;
`else
    acc_err    = !legal;
`endif
  end

  // Load formatting: bytes shifted in from beyond the beat are zero, so the
  // sign bit of a truncated misaligned load reads as 0 as well.
  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'd0:    begin keep = DATA_W'(8'hFF);        sign_bit = shifted[7];        end
      2'd1:    begin keep = DATA_W'(16'hFFFF);     sign_bit = shifted[15];       end
      2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31];       end
      default: begin keep = '1;                    sign_bit = shifted[DATA_W-1]; end
    endcase
    fmt = shifted & keep;
    if (!f3_q[2] && sign_bit) fmt = fmt | ~keep;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          f3_d  = bus.in_funct3;
          off_d = offset;
          we_d  = bus.in_wen;
          if (acc_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = {bus.in_addr[ADDR_W-1:OW], OW'(0)};
            wdata_d = bus.in_wdata << {offset, 3'b000};
            strb_d  = bus.in_wen ? (size_mask << offset) : '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = (we_q || bus.mem_rerr) ? '0 : fmt;
          err_d   = bus.mem_rerr;
          state_d = RESP;
        end
      end
      default: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = strb_q;
  assign bus.out_valid = (state_q == RESP);
  assign bus.out_rdata = rdata_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: bench for lsu_bus with one 32-bit and one 64-bit instance.
// Expected values come from a byte-oriented reference model of the access
// rules; stimulus is directed plus $urandom-driven transactions.
module tb_lsu_bus;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0, in_wen = 1'b0;
  logic [2:0]  in_f3 = '0;
  logic [31:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic        out_ready = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_rerr = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        o_in_ready, o_out_valid, o_out_err, o_mem_req, o_mem_we;
  logic [63:0] o_out_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wstrb;

  int total = 0;
  int bad   = 0;
  logic [63:0] seen_rdata, seen_wdata;
  logic [31:0] seen_addr;
  logic [7:0]  seen_strb;

  always #5 clk = ~clk;

  lsu_bus_if #(.ADDR_W(32), .DATA_W(32)) if32 ();
  lsu_bus_if #(.ADDR_W(32), .DATA_W(64)) if64 ();

  lsu_bus #(.ADDR_W(32), .DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  lsu_bus #(.ADDR_W(32), .DATA_W(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

  assign if32.in_valid   = in_valid & ~sel;
  assign if32.in_wen     = in_wen;
  assign if32.in_funct3  = in_f3;
  assign if32.in_addr    = in_addr;
  assign if32.in_wdata   = in_wdata[31:0];
  assign if32.out_ready  = out_ready & ~sel;
  assign if32.mem_gnt    = mem_gnt & ~sel;
  assign if32.mem_rvalid = mem_rvalid & ~sel;
  assign if32.mem_rdata  = mem_rdata[31:0];
  assign if32.mem_rerr   = mem_rerr;

  assign if64.in_valid   = in_valid & sel;
  assign if64.in_wen     = in_wen;
  assign if64.in_funct3  = in_f3;
  assign if64.in_addr    = in_addr;
  assign if64.in_wdata   = in_wdata;
  assign if64.out_ready  = out_ready & sel;
  assign if64.mem_gnt    = mem_gnt & sel;
  assign if64.mem_rvalid = mem_rvalid & sel;
  assign if64.mem_rdata  = mem_rdata;
  assign if64.mem_rerr   = mem_rerr;

  assign o_in_ready  = sel ? if64.in_ready  : if32.in_ready;
  assign o_out_valid = sel ? if64.out_valid : if32.out_valid;
  assign o_out_err   = sel ? if64.out_err   : if32.out_err;
  assign o_out_rdata = sel ? if64.out_rdata : {32'b0, if32.out_rdata};
  assign o_mem_req   = sel ? if64.mem_req   : if32.mem_req;
  assign o_mem_we    = sel ? if64.mem_we    : if32.mem_we;
  assign o_mem_addr  = sel ? if64.mem_addr  : if32.mem_addr;
  assign o_mem_wdata = sel ? if64.mem_wdata : {32'b0, if32.mem_wdata};
  assign o_mem_wstrb = sel ? if64.mem_wstrb : {4'b0, if32.mem_wstrb};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, byte by byte from the access rules.
  function automatic void model(
    input int unsigned dw, input logic wen, input logic [2:0] f3,
    input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd, input logic rerr,
    output logic trap, output logic [31:0] ea, output logic [7:0] es,
    output logic [63:0] ew, output logic [63:0] er, output logic ee);
    int unsigned nb, off, sz;
    logic legal, mis;
    logic [63:0] v;
    nb  = dw / 8;
    off = addr % nb;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2, 3'd6: sz = 4;
      default:    sz = 8;
    endcase
    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ||
            (dw == 64 && (f3 == 3 || f3 == 6));
    if (wen && f3 >= 4) legal = 1'b0;
    mis  = (off % sz) != 0;
    trap = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) trap = 1'b1;
`else
    if (mis) trap = trap;
`endif
    ea = addr - off;
    es = '0;
    ew = '0;
    v  = '0;
    for (int unsigned i = 0; i < nb; i++) begin
      if (wen && i >= off && i < off + sz) es[i] = 1'b1;
      if (i >= off) ew[8*i +: 8] = wd[8*(i-off) +: 8];
    end
    for (int unsigned j = 0; j < sz; j++)
      if (off + j < nb) v[8*j +: 8] = rd[8*(off+j) +: 8];
    if (f3 < 4 && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    if (dw == 32) v[63:32] = '0;
    er = (trap || wen || rerr) ? 64'd0 : v;
    ee = trap || rerr;
  endfunction

  // One full transaction: gd grant-delay cycles, rvd rvalid-delay cycles,
  // od cycles of response backpressure.
  task automatic txn(input logic s, input logic wen, input logic [2:0] f3,
                     input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                     input logic re, input int unsigned gd, input int unsigned rvd,
                     input int unsigned od);
    logic trap, ee;
    logic [31:0] ea;
    logic [7:0]  es;
    logic [63:0] ew, er;
    model(s ? 64 : 32, wen, f3, a, wd, rd, re, trap, ea, es, ew, er, ee);
    @(negedge clk);
    sel = s; in_valid = 1'b1; in_wen = wen; in_f3 = f3; in_addr = a; in_wdata = wd;
    #1 chk("accept_ready", {63'b0, o_in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (trap) begin
      chk("trap_no_req", {63'b0, o_mem_req}, 64'd0);
      chk("trap_valid_t1", {63'b0, o_out_valid}, 64'd1);
    end else begin
      seen_addr = o_mem_addr; seen_strb = o_mem_wstrb; seen_wdata = o_mem_wdata;
      for (int unsigned k = 0; k <= gd; k++) begin
        chk("req_hi", {63'b0, o_mem_req}, 64'd1);
        chk("req_addr", {32'b0, o_mem_addr}, {32'b0, ea});
        chk("req_we", {63'b0, o_mem_we}, {63'b0, wen});
        chk("req_strb", {56'b0, o_mem_wstrb}, {56'b0, es});
        if (wen) chk("req_wdata", o_mem_wdata, ew);
        chk("busy_not_ready", {63'b0, o_in_ready}, 64'd0);
        mem_gnt = (k == gd);
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      for (int unsigned k = 0; k <= rvd; k++) begin
        chk("wait_no_req", {63'b0, o_mem_req}, 64'd0);
        chk("wait_no_valid", {63'b0, o_out_valid}, 64'd0);
        mem_rvalid = (k == rvd); mem_rdata = rd; mem_rerr = re;
        @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = {$urandom, $urandom};
      chk("resp_valid", {63'b0, o_out_valid}, 64'd1);
    end
    seen_rdata = o_out_rdata;
    for (int unsigned k = 0; k <= od; k++) begin
      chk("resp_hold", {63'b0, o_out_valid}, 64'd1);
      chk("resp_rdata", o_out_rdata, er);
      chk("resp_err", {63'b0, o_out_err}, {63'b0, ee});
      chk("resp_not_ready", {63'b0, o_in_ready}, 64'd0);
      out_ready = (k == od);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("retire_valid_lo", {63'b0, o_out_valid}, 64'd0);
    chk("retire_idle", {63'b0, o_in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'b0, if32.in_ready}, 64'd0);
    chk("rst_in_ready64", {63'b0, if64.in_ready}, 64'd0);
    chk("rst_mem_req", {63'b0, o_mem_req}, 64'd0);
    chk("rst_out_valid", {63'b0, o_out_valid}, 64'd0);
    chk("rst_out_rdata", o_out_rdata, 64'd0);
    chk("rst_out_err", {63'b0, o_out_err}, 64'd0);
    chk("rst_mem_addr", {32'b0, o_mem_addr}, 64'd0);
    chk("rst_mem_strb", {56'b0, o_mem_wstrb}, 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {63'b0, o_in_ready}, 64'd1);

    // Directed cases
    txn(0, 0, 3'b010, 32'h8000_0004, 64'd0, 64'h8081_8283, 0, 0, 0, 0);
    chk("tp_lw_addr", {32'b0, seen_addr}, 64'h8000_0004);
    chk("tp_lw_data", seen_rdata, 64'h8081_8283);
    txn(0, 0, 3'b000, 32'h8000_0003, 64'd0, 64'h80AA_BBCC, 0, 0, 0, 0);
    chk("tp_lb", seen_rdata, 64'hFFFF_FF80);
    txn(0, 0, 3'b100, 32'h8000_0003, 64'd0, 64'h80AA_BBCC, 0, 0, 0, 0);
    chk("tp_lbu", seen_rdata, 64'h0000_0080);
    txn(0, 1, 3'b001, 32'h8000_0002, 64'h1234_ABCD, 64'hDEAD_BEEF, 0, 0, 0, 0);
    chk("tp_sh_strb", {56'b0, seen_strb}, 64'hC);
    chk("tp_sh_wdata", seen_wdata, 64'hABCD_0000);
    chk("tp_sh_rdata", seen_rdata, 64'd0);
    txn(0, 0, 3'b010, 32'h8000_0002, 64'd0, 64'h1122_3344, 0, 0, 0, 0);
    txn(0, 1, 3'b010, 32'h8000_0003, 64'hA1B2_C3D4, 64'd0, 0, 0, 0, 0);
    txn(0, 0, 3'b010, 32'h8000_0010, 64'd0, 64'h5555_AAAA, 0, 4, 1, 3);
    txn(0, 0, 3'b011, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0, 1);
    txn(0, 1, 3'b100, 32'h8000_0000, 64'd5, 64'd0, 0, 0, 0, 0);
    txn(0, 0, 3'b001, 32'h8000_0000, 64'd0, 64'h1234_8765, 1, 1, 0, 0);

    // Reset while waiting for the response beat
    @(negedge clk);
    sel = 1'b0; in_valid = 1'b1; in_wen = 1'b0; in_f3 = 3'b010; in_addr = 32'h100;
    @(negedge clk);
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("mid_wait_req_lo", {63'b0, o_mem_req}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_idle", {63'b0, o_in_ready}, 64'd1);
    chk("mid_rst_no_valid", {63'b0, o_out_valid}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_0BAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_no_valid", {63'b0, o_out_valid}, 64'd0);
    chk("late_rvalid_no_req", {63'b0, o_mem_req}, 64'd0);
    chk("late_rvalid_idle", {63'b0, o_in_ready}, 64'd1);
    txn(0, 0, 3'b010, 32'h100, 64'd0, 64'h7654_3210, 0, 0, 0, 0);

    // 64-bit datapath
    txn(1, 0, 3'b011, 32'h8, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0);
    chk("tp_ld64", seen_rdata, 64'hFEDC_BA98_7654_3210);
    txn(1, 0, 3'b010, 32'h4, 64'd0, 64'h8000_0001_1234_5678, 0, 0, 0, 0);
    txn(1, 0, 3'b110, 32'h4, 64'd0, 64'h8000_0001_1234_5678, 0, 0, 0, 0);
    txn(1, 1, 3'b011, 32'h10, 64'h0102_0304_0506_0708, 64'd0, 0, 1, 0, 1);
    txn(1, 1, 3'b001, 32'h6, 64'h0000_0000_0000_BEEF, 64'd0, 0, 0, 0, 0);

    // Randomized traffic on both widths
    for (int unsigned n = 0; n < 160; n++) begin
      txn(1'(n % 4 == 3), 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
          $urandom, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(7, 0) == 0, $urandom_range(3, 0), $urandom_range(2, 0),
          $urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_bus.md
# lsu_bus

Multi-cycle load/store unit that replaces the combinational, DPI-backed memory access path with a registered request/response engine on a simple handshake bus. It accepts one memory instruction at a time from the execute stage and computes an aligned address, byte strobes and lane-shifted store data. It drives a single-outstanding memory port, then returns sign- or zero-extended load data (or a write acknowledge) through a valid/ready response channel. Data width is parametrised for RV32 and RV64 datapaths.

## Interface

- ADDR_W, 32, address width in bits.
- DATA_W, 32, datapath and bus width; legal values 32 or 64. NB = DATA_W/8 bytes per beat.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accept; high only in IDLE.
- in_wen  in  1  1 = store, 0 = load.
- in_funct3  in  3  RISC-V size/sign encoding.
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  DATA_W  store data, right-aligned.
- out_valid  out  1  response valid.
- out_ready  in  1  response accept.
- out_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- out_err  out  1  access error: misaligned, illegal funct3, or bus error.
- mem_req  out  1  bus request.
- mem_gnt  in  1  bus grant; transfer when mem_req && mem_gnt.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  in_addr with low log2(NB) bits cleared.
- mem_wdata  out  DATA_W  in_wdata << (8*offset), truncated to DATA_W.
- mem_wstrb  out  NB  size mask << offset, truncated to NB bits; all 0 for loads.
- mem_rvalid  in  1  one pulse per granted transfer: read data or write ack.
- mem_rdata  in  DATA_W  read data, full beat.
- mem_rerr  in  1  bus error, qualified by mem_rvalid.

## Operation

- Sizes: funct3 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- When DATA_W=64, 011 ld/sd and 110 lwu are also legal.
- Every other encoding, including store funct3 with bit 2 set, is illegal.
- offset = in_addr[log2(NB)-1:0]. An access is misaligned when offset is not a multiple of its size.
- Load formatting: shift mem_rdata right by 8*offset, keep size bytes, sign-extend for lb/lh/lw (on RV64) and zero-extend for lbu/lhu/lwu.
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE to REQ: on in_valid && in_ready. All request fields are registered.
- IDLE to RESP: on an illegal funct3. No bus activity occurs and out_err=1.
- REQ: mem_req=1 with stable address/data/strobe until mem_gnt. Then go to WAIT.
- WAIT: hold until mem_rvalid. Capture the formatted data and mem_rerr, then go to RESP.
- RESP: out_valid=1 with out_rdata/out_err stable until out_ready. Then go to IDLE.
- mem_rvalid outside WAIT is ignored.
- Only one transaction is outstanding. A new request is never accepted in the same cycle a response retires.

## Timing

- Reset: state=IDLE, in_ready=0 in the reset cycle and 1 in the first cycle after it. All other outputs are 0.
- Accept in cycle T: mem_req rises at T+1.
- With a grant at T+1 and mem_rvalid at T+2, out_valid rises at T+3. Minimum load-to-use latency is 3 cycles after acceptance.
- The error path with no bus access raises out_valid at T+1.
- Bus outputs are registered and do not depend combinationally on mem_gnt.
- out_rdata/out_err are registered.
- Reset mid-operation in any state: return to IDLE next cycle and drop mem_req. A late mem_rvalid after that is ignored.

## Configuration

- LSU_MISALIGN_TRAP_EN defined: a misaligned access goes IDLE to RESP with out_err=1 and out_rdata=0. No mem_req is issued.
- Undefined: a misaligned access is issued on the bus. Strobe and data bits shifted past the beat are dropped, load bytes beyond the beat read as 0 before extension, and out_err reflects only mem_rerr.
- Illegal funct3 errors regardless of the macro.

## Test plan

- DATA_W=32, lw at 0x80000004, mem_rdata=0x80818283, immediate grant -> mem_addr 0x80000004, out_rdata 0x80818283 exactly 3 cycles after accept.
- lb at 0x80000003, mem_rdata=0x80AABBCC -> out_rdata 0xFFFFFF80; the same access with lbu -> 0x00000080.
- sh at 0x80000002, in_wdata 0x1234ABCD -> mem_we=1, mem_wstrb 4'b1100, mem_wdata 0xABCD0000; response out_rdata 0, out_err 0.
- lw at 0x80000002 with LSU_MISALIGN_TRAP_EN -> no mem_req, out_valid with out_err=1 at T+1. Without the macro -> mem_wstrb/lanes truncated, bus access issued.
- mem_gnt held low 4 cycles and out_ready held low 3 cycles -> mem_req/mem_addr stable through the wait, out_valid/out_rdata stable through backpressure, in_ready=0 throughout.
- rst asserted in WAIT, then mem_rvalid pulsed -> IDLE next cycle, no out_valid, and the next lw completes normally. DATA_W=64 ld at 0x8, mem_rdata 0xFEDCBA9876543210 -> same value returned.
